// File: rtl/sr_latch_exerciser.sv
// sr_latch_exerciser: steps a gated SR latch through a fixed 8-entry stimulus table.
// Each step is DRIVE (1 cycle), SETTLE (SETTLE_CYCLES cycles) and SAMPLE (1 cycle).
// In SAMPLE the Q and Q-bar readbacks are checked and any mismatches are counted.
// Optional macro SR_EXERCISER_STOP_ON_ERROR_EN: end the run at the first mismatch.
module sr_latch_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       latchOut,
  input  logic       latchNotout,
  output logic       latchEnable,
  output logic       latchSet,
  output logic       latchReset,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] errorCount,
  output logic [2:0] step
);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StSample, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LastStep   = 3'd7;
  localparam logic [2:0] SkipStep   = 3'd6;  // forbidden S=R=1 input, never compared

  state_e     state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic [2:0] step_q, step_d;
  logic [2:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic [2:0] drv_q, drv_d;  // {enable, set, reset}
  logic       exp_q;
  logic       mismatch;
  logic       finish;

  // Stimulus table: {enable, set, reset} per step.
  function automatic logic [2:0] step_drive(input logic [2:0] idx);
    logic [2:0] val;
    case (idx)
      3'd0:    val = 3'b101;
      3'd1:    val = 3'b010;
      3'd2:    val = 3'b110;
      3'd3:    val = 3'b100;
      3'd4:    val = 3'b001;
      3'd5:    val = 3'b101;
      3'd6:    val = 3'b111;
      default: val = 3'b110;
    endcase
    return val;
  endfunction

  // Expected Q per step; step 6 is a don't-care and is masked from the compare.
  function automatic logic step_expect(input logic [2:0] idx);
    logic val;
    case (idx)
      3'd2, 3'd3, 3'd4, 3'd7: val = 1'b1;
      default:                val = 1'b0;
    endcase
    return val;
  endfunction

  // Compare readbacks against the expected Q for the step being sampled.
  always_comb begin
    exp_q    = step_expect(step_q);
    mismatch = (step_q != SkipStep) && ((latchOut != exp_q) || (latchNotout != ~exp_q));
`ifdef SR_EXERCISER_STOP_ON_ERROR_EN
    finish   = (step_q == LastStep) || mismatch;
`else
    finish   = (step_q == LastStep);
`endif
  end

  // Next-state logic; latch drive values are registered on the edge entering DRIVE.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    step_d   = step_q;
    err_d    = err_q;
    pass_d   = pass_q;
    drv_d    = drv_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDrive;
          step_d  = 3'd0;
          err_d   = 3'd0;
          pass_d  = 1'b0;
          drv_d   = step_drive(3'd0);
        end
      end
      StDrive: begin
        state_d  = StSettle;
        settle_d = 4'd0;
      end
      StSettle: begin
        if (settle_q == SettleLast) begin
          state_d = StSample;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StSample: begin
        if (mismatch) begin
          err_d = err_q + 3'd1;
        end
        if (finish) begin
          state_d = StDone;
          pass_d  = (err_d == 3'd0);
        end else begin
          state_d = StDrive;
          step_d  = step_q + 3'd1;
          drv_d   = step_drive(step_q + 3'd1);
        end
      end
      StDone: begin
        state_d = StIdle;
        drv_d   = 3'b000;
      end
      default: begin
        state_d = StIdle;
        drv_d   = 3'b000;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      settle_q <= 4'd0;
      step_q   <= 3'd0;
      err_q    <= 3'd0;
      pass_q   <= 1'b0;
      drv_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      step_q   <= step_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      drv_q    <= drv_d;
    end
  end

  // Output decode.
  always_comb begin
    latchEnable = drv_q[2];
    latchSet    = drv_q[1];
    latchReset  = drv_q[0];
    busy        = (state_q == StDrive) || (state_q == StSettle) || (state_q == StSample);
    done        = (state_q == StDone);
    pass        = pass_q;
    errorCount  = err_q;
    step        = step_q;
  end

endmodule

// File: tb/tb_sr_latch_exerciser.sv
// Testbench for sr_latch_exerciser: behavioural gated SR latch with injectable readback
// faults, plus a second instance with SETTLE_CYCLES=1 for back-to-back runs.
module tb_sr_latch_exerciser;

  localparam int SETTLE = 2;
  localparam int P      = SETTLE + 2;
  localparam int PF     = 3;

  logic clock = 1'b0;
  logic reset, start, start_f;
  logic latchOut, latchNotout, latchEnable, latchSet, latchReset, busy, done, pass;
  logic [2:0] errorCount, step;
  logic latchOut_f, latchNotout_f, latchEnable_f, latchSet_f, latchReset_f;
  logic busy_f, done_f, pass_f;
  logic [2:0] errorCount_f, step_f;

  int checks = 0;
  int errors = 0;

  int         fault_mode = 0;  // 0 good, 1 Q stuck 0, 2 Qbar==Q, 3 per-step flip mask
  logic [7:0] flip_mask = 8'h00;
  logic       q_model = 1'b0;
  logic       q_fast = 1'b0;

  logic       obs_busy [0:127];
  logic [2:0] obs_step [0:127];
  logic [2:0] obs_drv  [0:127];

  always #5 clock = ~clock;

  sr_latch_exerciser #(.SETTLE_CYCLES(SETTLE)) dut (
    .clock(clock), .reset(reset), .start(start), .latchOut(latchOut),
    .latchNotout(latchNotout), .latchEnable(latchEnable), .latchSet(latchSet),
    .latchReset(latchReset), .busy(busy), .done(done), .pass(pass),
    .errorCount(errorCount), .step(step)
  );

  sr_latch_exerciser #(.SETTLE_CYCLES(1)) dut_fast (
    .clock(clock), .reset(reset), .start(start_f), .latchOut(latchOut_f),
    .latchNotout(latchNotout_f), .latchEnable(latchEnable_f), .latchSet(latchSet_f),
    .latchReset(latchReset_f), .busy(busy_f), .done(done_f), .pass(pass_f),
    .errorCount(errorCount_f), .step(step_f)
  );

  // Gated SR latches settle mid-cycle.
  always @(negedge clock) begin
    if (latchEnable) begin
      if (latchSet && !latchReset) q_model <= 1'b1;
      else if (!latchSet && latchReset) q_model <= 1'b0;
    end
    if (latchEnable_f) begin
      if (latchSet_f && !latchReset_f) q_fast <= 1'b1;
      else if (!latchSet_f && latchReset_f) q_fast <= 1'b0;
    end
  end

  always_comb begin
    latchOut      = q_model;
    latchNotout   = ~q_model;
    latchOut_f    = q_fast;
    latchNotout_f = ~q_fast;
    case (fault_mode)
      1: begin latchOut = 1'b0; latchNotout = 1'b1; end
      2: latchNotout = q_model;
      3: begin
        latchOut    = q_model ^ flip_mask[step];
        latchNotout = ~(q_model ^ flip_mask[step]);
      end
      default: ;
    endcase
  end

  function automatic logic [2:0] ref_drive(input int k);
    case (k)
      0: return 3'b101;
      1: return 3'b010;
      2: return 3'b110;
      3: return 3'b100;
      4: return 3'b001;
      5: return 3'b101;
      6: return 3'b111;
      default: return 3'b110;
    endcase
  endfunction

  // Expected Q per step, -1 = don't care.
  function automatic int ref_q(input int k);
    case (k)
      0, 1, 5: return 0;
      6: return -1;
      default: return 1;
    endcase
  endfunction

  // Which steps should produce a counted mismatch under a given fault.
  function automatic logic [7:0] mode_mask(input int mode, input logic [7:0] fm);
    logic [7:0] m = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (ref_q(k) >= 0) begin
        case (mode)
          1: m[k] = (ref_q(k) == 1);
          2: m[k] = 1'b1;
          3: m[k] = fm[k];
          default: m[k] = 1'b0;
        endcase
      end
    end
    return m;
  endfunction

  // Start a run and record per-cycle observations until done (or stop_at / bound).
  task automatic drive_run(input int repulse_at, input int stop_at, output int n,
                           output bit timeout);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (1) begin
      obs_busy[n] = busy;
      obs_step[n] = step;
      obs_drv[n]  = {latchEnable, latchSet, latchReset};
      if (done || n == stop_at || n >= 100) break;
      start = (n == repulse_at);
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    timeout = !done && (n != stop_at);
  endtask

  task automatic test_run(input string name, input int mode, input logic [7:0] fm,
                          input int repulse_at);
    logic [7:0] mm;
    int cnt, first, exp_err, exp_step, exp_n, n;
    bit to, exp_pass;
    fault_mode = mode;
    flip_mask  = fm;
    mm = mode_mask(mode, fm);
    cnt = 0; first = -1;
    for (int k = 0; k < 8; k++) if (mm[k]) begin cnt++; if (first < 0) first = k; end
`ifdef SR_EXERCISER_STOP_ON_ERROR_EN
    if (cnt > 0) begin exp_err = 1; exp_step = first; exp_n = P * (first + 1); end
    else begin exp_err = 0; exp_step = 7; exp_n = 8 * P; end
`else
    exp_err = cnt; exp_step = 7; exp_n = 8 * P;
`endif
    exp_pass = (exp_err == 0);
    drive_run(repulse_at, -1, n, to);
    checks++;
    if (to) begin errors++; $display("FAIL %s timeout: no done after %0d cycles", name, n); end
    checks++;
    if (n != exp_n) begin errors++; $display("FAIL %s done_cycle got %0d want %0d", name, n, exp_n); end
    checks++;
    if (errorCount !== 3'(exp_err)) begin
      errors++; $display("FAIL %s errorCount got %0d want %0d", name, errorCount, exp_err);
    end
    checks++;
    if (pass !== exp_pass) begin errors++; $display("FAIL %s pass got %b want %b", name, pass, exp_pass); end
    checks++;
    if (step !== 3'(exp_step)) begin
      errors++; $display("FAIL %s final_step got %0d want %0d", name, step, exp_step);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_in_done got %b want 0", name, busy); end
    for (int i = 0; i < exp_n && i <= n; i++) begin
      checks++;
      if (obs_busy[i] !== 1'b1 || obs_step[i] !== 3'(i / P) || obs_drv[i] !== ref_drive(i / P)) begin
        errors++;
        $display("FAIL %s cycle%0d busy/step/drv got %b/%0d/%b want 1/%0d/%b", name, i,
                 obs_busy[i], obs_step[i], obs_drv[i], i / P, ref_drive(i / P));
      end
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {latchEnable, latchSet, latchReset} !== 3'b000) begin
      errors++;
      $display("FAIL %s idle_after_done done/busy/drv got %b/%b/%b want 0/0/000", name, done,
               busy, {latchEnable, latchSet, latchReset});
    end
    checks++;
    if (errorCount !== 3'(exp_err) || pass !== exp_pass) begin
      errors++;
      $display("FAIL %s result_hold err/pass got %0d/%b want %0d/%b", name, errorCount, pass,
               exp_err, exp_pass);
    end
    fault_mode = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({latchEnable, latchSet, latchReset, busy, done, pass} !== 6'b0 ||
        errorCount !== 3'd0 || step !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got en%b s%b r%b busy%b done%b pass%b err%0d step%0d want all 0",
               latchEnable, latchSet, latchReset, busy, done, pass, errorCount, step);
    end
    checks++;
    if ({busy_f, done_f, pass_f, errorCount_f, step_f} !== 9'b0) begin
      errors++; $display("FAIL reset_state_fast got busy%b done%b want 0", busy_f, done_f);
    end
    start = 1'b0; reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority busy got %b want 0", busy); end
  endtask

  task automatic test_reset_midrun();
    int n;
    bit to;
    fault_mode = 1;
    drive_run(-1, 3 * P + 1, n, to);
    checks++;
    if (to || step !== 3'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_reach step/busy got %0d/%b want 3/1", step, busy);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if ({latchEnable, latchSet, latchReset, busy, done, pass} !== 6'b0 ||
        errorCount !== 3'd0 || step !== 3'd0) begin
      errors++;
      $display("FAIL midrun_reset got drv%b busy%b done%b pass%b err%0d step%0d want all 0",
               {latchEnable, latchSet, latchReset}, busy, done, pass, errorCount, step);
    end
    fault_mode = 0;
    test_run("after_reset", 0, 8'h00, -1);
  endtask

  task automatic test_back_to_back();
    int n;
    start_f = 1'b1;
    for (int run = 0; run < 2; run++) begin
      if (run == 0) begin @(posedge clock); #1; end
      n = 0;
      while (!done_f && n < 60) begin @(posedge clock); #1; n++; end
      checks++;
      if (n != 8 * PF) begin errors++; $display("FAIL b2b_run%0d cycles got %0d want %0d", run, n, 8 * PF); end
      checks++;
      if (pass_f !== 1'b1 || errorCount_f !== 3'd0) begin
        errors++; $display("FAIL b2b_run%0d pass/err got %b/%0d want 1/0", run, pass_f, errorCount_f);
      end
      @(posedge clock); #1;
      checks++;
      if (busy_f !== 1'b0 || done_f !== 1'b0 || {latchEnable_f, latchSet_f, latchReset_f} !== 3'b0) begin
        errors++; $display("FAIL b2b_idle%0d busy/done got %b/%b want 0/0", run, busy_f, done_f);
      end
      if (run == 1) start_f = 1'b0;
      @(posedge clock); #1;
      if (run == 0) begin
        checks++;
        if (busy_f !== 1'b1 || step_f !== 3'd0 ||
            {latchEnable_f, latchSet_f, latchReset_f} !== ref_drive(0)) begin
          errors++;
          $display("FAIL b2b_restart busy/step/drv got %b/%0d/%b want 1/0/%b", busy_f, step_f,
                   {latchEnable_f, latchSet_f, latchReset_f}, ref_drive(0));
        end
      end
    end
    repeat (30) @(posedge clock);
    #1;
    checks++;
    if (busy_f !== 1'b0) begin errors++; $display("FAIL b2b_stop busy got %b want 0", busy_f); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_f = 1'b0;
    test_reset();
    test_run("clean", 0, 8'h00, -1);
    test_run("stuck0", 1, 8'h00, -1);
    test_run("notout_eq", 2, 8'h00, -1);
    test_run("flip6_only", 3, 8'h40, -1);
    for (int i = 0; i < 6; i++) test_run("random", 3, 8'($urandom), -1);
    test_reset_midrun();
    test_run("repulse", 0, 8'h00, 5 * P + 1);
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
